// File: rtl/acia6850_ctrl.sv
// Bus-master sequencer for the 6850 ACIA: init (master reset + config), then status polling with
// RX/TX byte movement. Every access is 1 setup clk + BUS_HOLD cs clks; the RX stream holds until taken.
module acia6850_ctrl #(
  parameter logic [7:0] CTRL_WORD = 8'h15,
  parameter int         BUS_HOLD  = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reinit,
  output logic       init_done,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic [7:0] status,
  output logic       acia_cs,
  output logic       acia_rw_n,
  output logic       acia_rs,
  output logic [7:0] acia_dout,
  input  logic [7:0] acia_din
);

  typedef enum logic [2:0] {
    RST_WR = 3'd0,
    CFG_WR = 3'd1,
    POLL   = 3'd2,
    RX_RD  = 3'd3,
    TX_WR  = 3'd4
  } state_t;

  localparam logic [15:0] HOLD = 16'(BUS_HOLD);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_busy;
  logic [15:0] r_cnt;
  logic        r_reinit;
  logic        r_last_rx;
  logic        r_cs;
  logic        r_rw_n;
  logic        r_rs;
  logic [7:0]  r_dout;
  logic        r_tx_ready;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_rx_overrun;
  logic [7:0]  r_status;
  logic        r_init_done;

  logic        w_last;
  logic        w_start;
  logic        w_reinit;
  logic        w_goto_rst;
  logic        w_rx_can;
  logic        w_tx_can;
  logic        w_pick_rx;
  logic        w_pick_tx;
  logic        w_rw_n;
  logic        w_rs;
  logic [7:0]  w_dout;

  // r_state names the access on the bus; the next one starts on the edge that ends the current one.
  always_comb begin
    w_last       = r_busy && (r_cnt == HOLD);
    w_start      = !r_busy || w_last;
    w_reinit     = r_reinit || reinit;
    w_goto_rst   = w_last && w_reinit;
    w_rx_can     = acia_din[0] && !r_rx_valid;
    w_tx_can     = acia_din[1] && tx_valid;
    w_next_state = r_state;
    w_pick_rx    = 1'b0;
    w_pick_tx    = 1'b0;
    if (w_last) begin
      if (w_reinit) begin
        w_next_state = RST_WR;
      end else begin
        case (r_state)
          RST_WR: w_next_state = CFG_WR;
          CFG_WR: w_next_state = POLL;
          POLL: begin
            if (w_rx_can && w_tx_can) begin
              w_pick_rx = !r_last_rx;
              w_pick_tx = r_last_rx;
            end else begin
              w_pick_rx = w_rx_can;
              w_pick_tx = w_tx_can;
            end
            if (w_pick_rx)      w_next_state = RX_RD;
            else if (w_pick_tx) w_next_state = TX_WR;
            else                w_next_state = POLL;
          end
          default: w_next_state = POLL;
        endcase
      end
    end
  end

  always_comb begin
    w_rw_n = 1'b1;
    w_rs   = 1'b0;
    w_dout = 8'h00;
    case (w_next_state)
      RST_WR: begin w_rw_n = 1'b0; w_dout = 8'h03;     end
      CFG_WR: begin w_rw_n = 1'b0; w_dout = CTRL_WORD; end
      RX_RD:  begin w_rs = 1'b1;                       end
      TX_WR:  begin w_rw_n = 1'b0; w_rs = 1'b1; w_dout = tx_data; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RST_WR;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_cnt    <= 16'd0;
      r_cs     <= 1'b0;
      r_rw_n   <= 1'b1;
      r_rs     <= 1'b0;
      r_dout   <= 8'h00;
      r_tx_ready <= 1'b0;
    end else begin
      r_tx_ready <= 1'b0;
      if (w_start) begin
        r_busy     <= 1'b1;
        r_cnt      <= 16'd0;
        r_cs       <= 1'b0;
        r_rw_n     <= w_rw_n;
        r_rs       <= w_rs;
        r_dout     <= w_dout;
        r_tx_ready <= (w_next_state == TX_WR);
      end else begin
        r_cnt <= r_cnt + 16'd1;
        r_cs  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reinit     <= 1'b0;
      r_last_rx    <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_status     <= 8'h00;
      r_init_done  <= 1'b0;
    end else begin
      if (w_goto_rst)  r_reinit <= 1'b0;
      else if (reinit) r_reinit <= 1'b1;

      if (r_init_done && r_rx_valid && rx_ready) r_rx_valid <= 1'b0;

      if (w_pick_rx) r_last_rx <= 1'b1;
      if (w_pick_tx) r_last_rx <= 1'b0;

      if (w_last) begin
        case (r_state)
          CFG_WR: r_init_done <= 1'b1;
          POLL: begin
            r_status <= acia_din;
            if (acia_din[5]) r_rx_overrun <= 1'b1;
          end
          RX_RD: begin
            r_rx_data  <= acia_din;
            r_rx_valid <= 1'b1;
          end
          default: ;
        endcase
      end

      // Reinit takes precedence over whatever the finishing access would have set.
      if (w_goto_rst) begin
        r_init_done  <= 1'b0;
        r_rx_valid   <= 1'b0;
        r_rx_overrun <= 1'b0;
      end
    end
  end

  assign acia_cs    = r_cs;
  assign acia_rw_n  = r_rw_n;
  assign acia_rs    = r_rs;
  assign acia_dout  = r_dout;
  assign tx_ready   = r_tx_ready;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_overrun = r_rx_overrun;
  assign status     = r_status;
  assign init_done  = r_init_done;

endmodule

// File: tb/tb_acia6850_ctrl.sv
// Directed bench for acia6850_ctrl with BUS_HOLD=2 and a behavioural ACIA register model.
module tb_acia6850_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reinit = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] m_status = 8'h00;
  logic [7:0] m_rxbyte = 8'h00;
  logic       init_done, tx_ready, rx_valid, rx_overrun;
  logic [7:0] rx_data, status, acia_dout, acia_din;
  logic       acia_cs, acia_rw_n, acia_rs;

  int errors = 0;
  int checks = 0;

  logic [9:0] log_q[$];
  logic       prev_cs = 1'b0;

  acia6850_ctrl #(.CTRL_WORD(8'h15), .BUS_HOLD(2)) dut (
    .clk(clk), .reset(reset), .reinit(reinit), .init_done(init_done),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .status(status),
    .acia_cs(acia_cs), .acia_rw_n(acia_rw_n), .acia_rs(acia_rs),
    .acia_dout(acia_dout), .acia_din(acia_din)
  );

  always #5 clk = ~clk;

  assign acia_din = acia_rs ? m_rxbyte : m_status;

  // Access log entry: {rw_n, rs, dout} captured when cs rises.
  always @(negedge clk) begin
    if (acia_cs && !prev_cs) log_q.push_back({acia_rw_n, acia_rs, acia_dout});
    prev_cs = acia_cs;
  end

  task automatic sync_setup();
    int n = 0;
    @(negedge clk);
    while (acia_cs !== 1'b0 && n < 10) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({acia_cs, acia_rw_n, acia_rs, acia_dout} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL reset_bus got=%b exp=%b", {acia_cs, acia_rw_n, acia_rs, acia_dout}, 11'b01000000000);
    end
    checks++;
    if ({tx_ready, rx_valid, rx_overrun, init_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {tx_ready, rx_valid, rx_overrun, init_done});
    end
    checks++;
    if ({rx_data, status} !== 16'h0000) begin
      errors++; $display("FAIL reset_data got=%h exp=0000", {rx_data, status});
    end
  endtask

  task automatic test_init();
    logic [0:9] pat;
    pat = 10'b0110110110;
    reset = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (acia_cs !== pat[n-1]) begin
        errors++; $display("FAIL init_cs clk=%0d got=%b exp=%b", n, acia_cs, pat[n-1]);
      end
      if (n == 1) begin
        checks++;
        if ({acia_rw_n, acia_rs, acia_dout} !== {1'b0, 1'b0, 8'h03}) begin
          errors++; $display("FAIL init_rst_wr got=%h exp=003", {acia_rw_n, acia_rs, acia_dout});
        end
      end
      if (n == 4) begin
        checks++;
        if ({acia_rw_n, acia_rs, acia_dout} !== {1'b0, 1'b0, 8'h15}) begin
          errors++; $display("FAIL init_cfg_wr got=%h exp=015", {acia_rw_n, acia_rs, acia_dout});
        end
      end
      if (n == 6) begin
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early got=%b exp=0", init_done); end
      end
      if (n == 7 || n == 10) begin
        checks++;
        if ({init_done, acia_rw_n, acia_rs} !== 3'b110) begin
          errors++; $display("FAIL init_poll clk=%0d got=%b exp=110", n, {init_done, acia_rw_n, acia_rs});
        end
      end
    end
  endtask

  task automatic test_tx();
    int n;
    sync_setup();
    #1 log_q.delete();
    m_status = 8'h02; tx_valid = 1'b1; tx_data = 8'h41;
    n = 0;
    do begin @(negedge clk); n++; end while (tx_ready !== 1'b1 && n < 20);
    checks++;
    if ({tx_ready, acia_cs, acia_rw_n, acia_rs, acia_dout} !== {4'b1001, 8'h41}) begin
      errors++; $display("FAIL tx1_setup got=%h exp=%h", {tx_ready, acia_cs, acia_rw_n, acia_rs, acia_dout}, {4'b1001, 8'h41});
    end
    @(posedge clk); #1 tx_data = 8'h42;
    @(negedge clk);
    checks++;
    if ({tx_ready, acia_cs, acia_dout} !== {2'b01, 8'h41}) begin
      errors++; $display("FAIL tx1_hold got=%h exp=%h", {tx_ready, acia_cs, acia_dout}, {2'b01, 8'h41});
    end
    n = 0;
    do begin @(negedge clk); n++; end while (tx_ready !== 1'b1 && n < 20);
    checks++;
    if ({tx_ready, acia_rw_n, acia_rs, acia_dout} !== {3'b101, 8'h42}) begin
      errors++; $display("FAIL tx2_setup got=%h exp=%h", {tx_ready, acia_rw_n, acia_rs, acia_dout}, {3'b101, 8'h42});
    end
    @(posedge clk); #1 tx_valid = 1'b0; tx_data = 8'hFF;
    m_status = 8'h00;
    repeat (9) @(negedge clk);
    checks++;
    if (log_q.size() < 5) begin
      errors++; $display("FAIL tx_log_len got=%0d exp>=5", log_q.size());
    end else if ({log_q[0], log_q[1], log_q[2], log_q[3], log_q[4]} !== {10'h200, 10'h141, 10'h200, 10'h142, 10'h200}) begin
      errors++; $display("FAIL tx_order got=%h %h %h %h %h exp=200 141 200 142 200", log_q[0], log_q[1], log_q[2], log_q[3], log_q[4]);
    end
  endtask

  task automatic test_alternation();
    logic [9:0] exp_q[6];
    exp_q = '{10'h200, 10'h300, 10'h200, 10'h177, 10'h200, 10'h300};
    rx_ready = 1'b1; m_rxbyte = 8'h11;
    sync_setup();
    #1 log_q.delete();
    m_status = 8'h03; tx_valid = 1'b1; tx_data = 8'h77;
    repeat (20) @(negedge clk);
    m_status = 8'h00;
    repeat (6) @(negedge clk);
    tx_valid = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= log_q.size()) begin
        errors++; $display("FAIL alt_order idx=%0d got=missing exp=%h", i, exp_q[i]);
      end else if (log_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL alt_order idx=%0d got=%h exp=%h", i, log_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_rx();
    int n;
    int rd;
    rx_ready = 1'b0; m_rxbyte = 8'h5A;
    sync_setup();
    #1 log_q.delete();
    m_status = 8'h01;
    n = 0;
    do begin @(negedge clk); n++; end while (rx_valid !== 1'b1 && n < 20);
    checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL rx1 got=%h exp=15a", {rx_valid, rx_data});
    end
    repeat (15) @(negedge clk);
    rd = 0;
    foreach (log_q[i]) if (log_q[i][9:8] == 2'b11) rd++;
    checks++;
    if (rd !== 1 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL rx_hold got=reads %0d valid %b exp=reads 1 valid 1", rd, rx_valid);
    end
    rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    m_rxbyte = 8'h3C;
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_take got=%b exp=0", rx_valid); end
    n = 0;
    do begin @(negedge clk); n++; end while (rx_valid !== 1'b1 && n < 20);
    checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h3C}) begin
      errors++; $display("FAIL rx2 got=%h exp=13c", {rx_valid, rx_data});
    end
    m_status = 8'h00;
  endtask

  task automatic test_reinit();
    int n;
    sync_setup();
    m_status = 8'h22;
    n = 0;
    do begin @(negedge clk); n++; end while (acia_cs !== 1'b1 && n < 10);
    n = 0;
    do begin @(negedge clk); n++; end while (acia_cs !== 1'b0 && n < 10);
    m_status = 8'h00;
    checks++;
    if ({rx_overrun, status} !== {1'b1, 8'h22}) begin
      errors++; $display("FAIL ovrn_set got=%h exp=122", {rx_overrun, status});
    end
    repeat (10) @(negedge clk);
    checks++;
    if ({rx_overrun, status, rx_valid} !== {1'b1, 8'h00, 1'b1}) begin
      errors++; $display("FAIL ovrn_sticky got=%h exp=201", {rx_overrun, status, rx_valid});
    end
    sync_setup();
    @(negedge clk);
    #1 log_q.delete();
    reinit = 1'b1;
    @(posedge clk); #1 reinit = 1'b0;
    @(negedge clk);
    checks++;
    if ({init_done, acia_cs} !== 2'b11) begin
      errors++; $display("FAIL reinit_finish got=%b exp=11", {init_done, acia_cs});
    end
    @(negedge clk);
    checks++;
    if ({init_done, rx_overrun, rx_valid, acia_cs, acia_rw_n, acia_rs, acia_dout} !== {6'b000000, 8'h03}) begin
      errors++; $display("FAIL reinit_rst got=%h exp=003", {init_done, rx_overrun, rx_valid, acia_cs, acia_rw_n, acia_rs, acia_dout});
    end
    n = 0;
    do begin @(negedge clk); n++; end while (init_done !== 1'b1 && n < 20);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL reinit_done_time got=%0d exp=6", n); end
    checks++;
    if (log_q.size() < 2) begin
      errors++; $display("FAIL reinit_log_len got=%0d exp>=2", log_q.size());
    end else if ({log_q[0], log_q[1]} !== {10'h003, 10'h015}) begin
      errors++; $display("FAIL reinit_order got=%h %h exp=003 015", log_q[0], log_q[1]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    m_status = 8'h02; tx_valid = 1'b1; tx_data = 8'h99;
    n = 0;
    do begin @(negedge clk); n++; end while (tx_ready !== 1'b1 && n < 20);
    @(posedge clk); #1;
    checks++;
    if ({acia_cs, acia_rw_n, acia_rs, acia_dout} !== {3'b101, 8'h99}) begin
      errors++; $display("FAIL mid_tx_hold got=%h exp=%h", {acia_cs, acia_rw_n, acia_rs, acia_dout}, {3'b101, 8'h99});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({acia_cs, acia_rw_n, tx_ready, init_done} !== 4'b0100) begin
      errors++; $display("FAIL mid_reset got=%b exp=0100", {acia_cs, acia_rw_n, tx_ready, init_done});
    end
    tx_valid = 1'b0; m_status = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({acia_cs, acia_rw_n, acia_rs, acia_dout} !== {3'b000, 8'h03}) begin
      errors++; $display("FAIL mid_restart got=%h exp=003", {acia_cs, acia_rw_n, acia_rs, acia_dout});
    end
    @(negedge clk);
    checks++;
    if ({acia_cs, acia_dout} !== {1'b1, 8'h03}) begin
      errors++; $display("FAIL mid_restart_cs got=%h exp=103", {acia_cs, acia_dout});
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_tx();
    test_alternation();
    test_rx();
    test_reinit();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
